// File: rtl/fibo_ctrl.sv
// rtl/fibo_ctrl.sv - Fibonacci sequencing controller for fibo_datapath (optional macro: FIBO_CTRL_OVF_EN)
//
// Register usage in the datapath: R0 = a, R1 = b, R2 = constant 1, R3 = remaining iterations.
// Each iteration computes b' = a + b, decrements the counter, then recovers a' = b' - a.
// All control outputs are registered: they are computed from the next state and
// presented during the cycle the FSM spends in that state.

module fibo_ctrl #(
    parameter int         SIZE   = 4,
    parameter logic [2:0] OP_ADD = 3'b000,
    parameter logic [2:0] OP_SUB = 3'b001
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] n,
    input  logic [SIZE-1:0] data,
    input  logic            zero_flag,
    output logic [SIZE-1:0] count,
    output logic            load_data,
    output logic [1:0]      wrt_addr,
    output logic            wrt_en,
    output logic [1:0]      rd_addr1,
    output logic [1:0]      rd_addr2,
    output logic [2:0]      alu_opcode,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] result,
    output logic            ovf
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_INIT0  = 4'd1,
        S_INIT1  = 4'd2,
        S_INIT2  = 4'd3,
        S_INIT3  = 4'd4,
        S_ADD    = 4'd5,
        S_WB_SUM = 4'd6,
        S_WB_CNT = 4'd7,
        S_WB_A   = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    localparam logic [1:0] R_A   = 2'd0;
    localparam logic [1:0] R_B   = 2'd1;
    localparam logic [1:0] R_ONE = 2'd2;
    localparam logic [1:0] R_CNT = 2'd3;

    localparam logic [SIZE-1:0] ZERO_W = '0;
    localparam logic [SIZE-1:0] ONE_W  = SIZE'(1);

    state_t            r_state;
    state_t            w_next;
    logic [SIZE-1:0]   r_n;
    logic              r_last;
    logic              w_start_acc;

    logic [SIZE-1:0]   w_count;
    logic              w_load_data;
    logic [1:0]        w_wrt_addr;
    logic              w_wrt_en;
    logic [1:0]        w_rd_addr1;
    logic [1:0]        w_rd_addr2;
    logic [2:0]        w_alu_opcode;
    logic              w_busy;

    assign w_start_acc = (r_state == S_IDLE) && start;

    // Next-state decode; start is only looked at in IDLE, and n==0 skips the loop entirely
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (n == ZERO_W) ? S_DONE : S_INIT0;
                end
            end
            S_INIT0:  w_next = S_INIT1;
            S_INIT1:  w_next = S_INIT2;
            S_INIT2:  w_next = S_INIT3;
            S_INIT3:  w_next = S_ADD;
            S_ADD:    w_next = S_WB_SUM;
            S_WB_SUM: w_next = S_WB_CNT;
            S_WB_CNT: w_next = S_WB_A;
            S_WB_A:   w_next = r_last ? S_DONE : S_ADD;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Control word for the state being entered, so the registered outputs line up with it
    always_comb begin
        w_count      = ZERO_W;
        w_load_data  = 1'b0;
        w_wrt_addr   = R_A;
        w_wrt_en     = 1'b0;
        w_rd_addr1   = R_A;
        w_rd_addr2   = R_A;
        w_alu_opcode = OP_ADD;
        w_busy       = 1'b1;
        case (w_next)
            S_INIT0: begin
                w_load_data = 1'b1;
                w_wrt_addr  = R_A;
                w_wrt_en    = 1'b1;
                w_count     = ZERO_W;
            end
            S_INIT1: begin
                w_load_data = 1'b1;
                w_wrt_addr  = R_B;
                w_wrt_en    = 1'b1;
                w_count     = ONE_W;
            end
            S_INIT2: begin
                w_load_data = 1'b1;
                w_wrt_addr  = R_ONE;
                w_wrt_en    = 1'b1;
                w_count     = ONE_W;
            end
            S_INIT3: begin
                w_load_data = 1'b1;
                w_wrt_addr  = R_CNT;
                w_wrt_en    = 1'b1;
                w_count     = r_n;
            end
            S_ADD: begin
                w_rd_addr1   = R_A;
                w_rd_addr2   = R_B;
                w_alu_opcode = OP_ADD;
            end
            S_WB_SUM: begin
                // Store a+b into b while the ALU evaluates counter-1 for the exit test
                w_wrt_addr   = R_B;
                w_wrt_en     = 1'b1;
                w_rd_addr1   = R_CNT;
                w_rd_addr2   = R_ONE;
                w_alu_opcode = OP_SUB;
            end
            S_WB_CNT: begin
                // Store counter-1 while the ALU recovers the old b as b' - a
                w_wrt_addr   = R_CNT;
                w_wrt_en     = 1'b1;
                w_rd_addr1   = R_B;
                w_rd_addr2   = R_A;
                w_alu_opcode = OP_SUB;
            end
            S_WB_A: begin
                w_wrt_addr = R_A;
                w_wrt_en   = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // Main FSM: state, registered control outputs, loop-exit flag and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_n        <= ZERO_W;
            r_last     <= 1'b0;
            count      <= ZERO_W;
            load_data  <= 1'b0;
            wrt_addr   <= 2'd0;
            wrt_en     <= 1'b0;
            rd_addr1   <= 2'd0;
            rd_addr2   <= 2'd0;
            alu_opcode <= OP_ADD;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= ZERO_W;
        end else begin
            r_state    <= w_next;
            count      <= w_count;
            load_data  <= w_load_data;
            wrt_addr   <= w_wrt_addr;
            wrt_en     <= w_wrt_en;
            rd_addr1   <= w_rd_addr1;
            rd_addr2   <= w_rd_addr2;
            alu_opcode <= w_alu_opcode;
            busy       <= w_busy;
            done       <= (w_next == S_DONE);

            if (w_start_acc) begin
                r_n <= n;
                if (n == ZERO_W) begin
                    result <= ZERO_W;
                end
            end

            // zero_flag here reflects counter-1 == 0, i.e. this is the final iteration
            if (r_state == S_WB_SUM) begin
                r_last <= zero_flag;
            end

            // data now holds the recovered old b, which is the new a
            if ((r_state == S_WB_A) && r_last) begin
                result <= data;
            end
        end
    end

`ifdef FIBO_CTRL_OVF_EN
    logic [SIZE-1:0] r_a_shadow;
    logic            r_ovf;

    // Track a alongside the datapath and flag any wrapped b' = a + b except the final unused one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_shadow <= ZERO_W;
            r_ovf      <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_ovf <= 1'b0;
            end
            if (r_state == S_INIT3) begin
                r_a_shadow <= ZERO_W;
            end
            if (r_state == S_WB_A) begin
                r_a_shadow <= data;
            end
            if ((r_state == S_WB_SUM) && !zero_flag && (data < r_a_shadow)) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fibo_ctrl.sv
// tb/tb_fibo_ctrl.sv - scoreboard bench for fibo_ctrl driving a behavioural fibo_datapath model

module tb_fibo_ctrl;

    localparam int         SIZE   = 4;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

`ifdef FIBO_CTRL_OVF_EN
    localparam logic OVF_N8 = 1'b1;
`else
    localparam logic OVF_N8 = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [SIZE-1:0] n = '0;
    logic [SIZE-1:0] data;
    logic            zero_flag;
    logic [SIZE-1:0] count;
    logic            load_data;
    logic [1:0]      wrt_addr;
    logic            wrt_en;
    logic [1:0]      rd_addr1;
    logic [1:0]      rd_addr2;
    logic [2:0]      alu_opcode;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] result;
    logic            ovf;

    fibo_ctrl #(.SIZE(SIZE), .OP_ADD(OP_ADD), .OP_SUB(OP_SUB)) dut (
        .clk(clk), .rst(rst), .start(start), .n(n), .data(data), .zero_flag(zero_flag),
        .count(count), .load_data(load_data), .wrt_addr(wrt_addr), .wrt_en(wrt_en),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .alu_opcode(alu_opcode),
        .busy(busy), .done(done), .result(result), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Datapath model: 4-entry register file without reset, ALU with registered output
    logic [SIZE-1:0] rf [4];
    logic [SIZE-1:0] alu_y;

    always_comb begin
        alu_y = '0;
        if (alu_opcode == OP_ADD)      alu_y = rf[rd_addr1] + rf[rd_addr2];
        else if (alu_opcode == OP_SUB) alu_y = rf[rd_addr1] - rf[rd_addr2];
        zero_flag = (alu_y == '0);
    end

    always @(posedge clk) begin
        if (wrt_en) rf[wrt_addr] <= load_data ? count : data;
        data <= alu_y;
    end

    typedef struct {
        int              cyc;
        logic [SIZE-1:0] res;
        logic            ovf;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse pops one expectation and compares timing, result and ovf
    always @(negedge clk) begin
        if (!rst && done) begin
            chk("done_single_pulse", int'(prev_done), 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending request (cycle %0d)", cyc);
            end else begin
                m_e = sb.pop_front();
                chk("done_cycle", cyc, m_e.cyc);
                chk("result", int'(result), int'(m_e.res));
                chk("ovf", int'(ovf), int'(m_e.ovf));
            end
        end
        prev_done = done;
    end

    task automatic check_reset();
        chk("rst_count", int'(count), 0);
        chk("rst_load_data", int'(load_data), 0);
        chk("rst_wrt_addr", int'(wrt_addr), 0);
        chk("rst_wrt_en", int'(wrt_en), 0);
        chk("rst_rd_addr1", int'(rd_addr1), 0);
        chk("rst_rd_addr2", int'(rd_addr2), 0);
        chk("rst_alu_opcode", int'(alu_opcode), int'(OP_ADD));
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_ovf", int'(ovf), 0);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (!busy && !done) ok = 1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=%0d done=%0d expected idle within 200 cycles", busy, done);
        end
    endtask

    // Issue one request; stray>0 pulses a start with n=3 in that cycle, rst_at>0 resets in that cycle
    task automatic run(input logic [SIZE-1:0] nv, input logic [SIZE-1:0] exp_res,
                       input logic exp_ovf, input int stray, input int rst_at);
        int rel;
        int last;
        int busy_bad = 0;
        int wr = 0;
        logic exp_busy;
        rel  = (nv == 0) ? 1 : 4 * int'(nv) + 5;
        last = (rst_at != 0) ? rst_at : rel;
        wait_idle();
        start = 1'b1;
        n     = nv;
        if (rst_at == 0) sb.push_back('{cyc + rel, exp_res, exp_ovf});
        for (int m = 1; m <= last; m++) begin
            @(negedge clk);
            start = (m == stray);
            if (m == stray) n = 4'd3;
            if (rst_at != 0 && m == rst_at) begin
                rst = 1'b1;
                break;
            end
            exp_busy = (nv != 0) && (m < rel);
            if (busy !== exp_busy) busy_bad++;
            if (wrt_en) wr++;
        end
        start = 1'b0;
        if (rst_at == 0) begin
            chk($sformatf("busy_window_n%0d", nv), busy_bad, 0);
            chk($sformatf("wrt_pulses_n%0d", nv), wr, (nv == 0) ? 0 : 4 + 3 * int'(nv));
        end else begin
            @(negedge clk);
            check_reset();
            rst = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset();
        rst = 1'b0;

        run(4'd5, 4'd5,  1'b0,   6, 0);
        run(4'd0, 4'd0,  1'b0,   0, 0);
        run(4'd1, 4'd1,  1'b0,   0, 0);
        run(4'd7, 4'd13, 1'b0,   0, 0);
        run(4'd8, 4'd5,  OVF_N8, 0, 0);
        run(4'd1, 4'd1,  1'b0,   0, 0);
        run(4'd6, 4'd0,  1'b0,   0, 10);
        run(4'd4, 4'd3,  1'b0,   0, 0);

        repeat (3) @(negedge clk);
        chk("result_held", int'(result), 3);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
